// File: rtl/id_scoreboard.sv
// Decode-stage register hazard scoreboard: per-register pending write-back counters,
// RAW / counter-full stall generation, sticky underflow error and a stall-cycle counter.
module id_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic              reg1_read_i,
  input  logic [ADDR_W-1:0] reg1_addr_i,
  input  logic              reg2_read_i,
  input  logic [ADDR_W-1:0] reg2_addr_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              issue_o,
  output logic              err_o,
  output logic [15:0]       stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pend_v [REG_NUM];
  logic [CNT_W-1:0] pend_r1, pend_r2, pend_w, pend_wb;
  logic             raw1, raw2, waw_full;
  logic             inc_en, dec_en, same_reg;
  logic             err_q, err_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  assign pend_r1 = pend_v[reg1_addr_i];
  assign pend_r2 = pend_v[reg2_addr_i];
  assign pend_w  = pend_v[waddr_i];
  assign pend_wb = pend_v[wb_addr_i];

  assign raw1     = reg1_read_i && (reg1_addr_i != '0) && (pend_r1 != '0);
  assign raw2     = reg2_read_i && (reg2_addr_i != '0) && (pend_r2 != '0);
  assign waw_full = reg_write_i && (waddr_i != '0) && (pend_w == CNT_MAX);

  assign stall_o = id_valid_i & ~flush_i & (raw1 | raw2 | waw_full);
  assign issue_o = id_valid_i & ~flush_i & ~stall_o;

  // A flush discards the write-back of its cycle, so it cannot raise the error either.
  assign inc_en   = issue_o & reg_write_i & (waddr_i != '0);
  assign dec_en   = wb_valid_i & ~flush_i & (wb_addr_i != '0);
  assign same_reg = inc_en & dec_en & (waddr_i == wb_addr_i);

  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign pend_v[gi] = '0;
      end else begin : g_cnt
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             inc, dec;

        assign inc = inc_en && (waddr_i == ADDR_W'(gi));
        assign dec = dec_en && (wb_addr_i == ADDR_W'(gi));

        always_comb begin
          pend_d = pend_q;
          if (flush_i) begin
            pend_d = '0;
          end else if (inc && !dec) begin
            pend_d = pend_q + CNT_W'(1);
          end else if (dec && !inc && (pend_q != '0)) begin
            pend_d = pend_q - CNT_W'(1);
          end
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) pend_q <= '0;
          else      pend_q <= pend_d;
        end

        assign pend_v[gi] = pend_q;
      end
    end
  endgenerate

  always_comb begin
    err_d       = err_q | (dec_en & ~same_reg & (pend_wb == '0));
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed, table-driven bench for id_scoreboard plus hand-written sequences for
// stall-counter saturation and asynchronous mid-run reset.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, reg1_read_i, reg2_read_i, reg_write_i, wb_valid_i, flush_i;
  logic [4:0]  reg1_addr_i, reg2_addr_i, waddr_i, wb_addr_i;
  logic        stall_o, issue_o, err_o;
  logic [15:0] stall_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_scoreboard #(.REG_NUM(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i),
    .reg1_read_i(reg1_read_i), .reg1_addr_i(reg1_addr_i),
    .reg2_read_i(reg2_read_i), .reg2_addr_i(reg2_addr_i),
    .reg_write_i(reg_write_i), .waddr_i(waddr_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .flush_i(flush_i),
    .stall_o(stall_o), .issue_o(issue_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic       v;
    logic       r1;
    logic [4:0] a1;
    logic       r2;
    logic [4:0] a2;
    logic       w;
    logic [4:0] wa;
    logic       wb;
    logic [4:0] wba;
    logic       fl;
    logic       es;
    logic       ei;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, r1, input logic [4:0] a1, input logic r2,
                     input logic [4:0] a2, input logic w, input logic [4:0] wa,
                     input logic wb, input logic [4:0] wba, input logic fl,
                     input logic es, ei, ee);
    vec_t t;
    t.v = v; t.r1 = r1; t.a1 = a1; t.r2 = r2; t.a2 = a2; t.w = w; t.wa = wa;
    t.wb = wb; t.wba = wba; t.fl = fl; t.es = es; t.ei = ei; t.ee = ee;
    tbl.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    id_valid_i  = t.v;
    reg1_read_i = t.r1; reg1_addr_i = t.a1;
    reg2_read_i = t.r2; reg2_addr_i = t.a2;
    reg_write_i = t.w;  waddr_i     = t.wa;
    wb_valid_i  = t.wb; wb_addr_i   = t.wba;
    flush_i     = t.fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    vec_t t;
    t = '{default: '0};
    drive(t);
  endtask

  initial begin
    vec_t t;
    int   n_sat;

    // RAW stall and release on r3
    add(1,1,5,0,0,0,0,0,0,0, 0,1,0);
    add(1,0,0,0,0,1,3,0,0,0, 0,1,0);
    add(1,1,3,0,0,0,0,0,0,0, 1,0,0);
    add(1,1,3,0,0,0,0,0,0,0, 1,0,0);
    add(1,1,3,0,0,0,0,0,0,0, 1,0,0);
    add(1,1,3,0,0,0,0,1,3,0, 1,0,0);
    add(1,1,3,0,0,0,0,0,0,0, 0,1,0);
    // r0 exemption
    add(1,0,0,0,0,1,0,0,0,0, 0,1,0);
    add(1,1,0,1,0,0,0,0,0,0, 0,1,0);
    add(1,1,0,1,0,1,0,1,0,0, 0,1,0);
    add(1,1,0,0,0,0,0,0,0,0, 0,1,0);
    // counter saturation on r7
    add(1,0,0,0,0,1,7,0,0,0, 0,1,0);
    add(1,0,0,0,0,1,7,0,0,0, 0,1,0);
    add(1,0,0,0,0,1,7,0,0,0, 0,1,0);
    add(1,0,0,0,0,1,7,0,0,0, 1,0,0);
    add(1,0,0,0,0,1,7,1,7,0, 1,0,0);
    add(1,0,0,0,0,1,7,0,0,0, 0,1,0);
    add(1,0,0,1,7,0,0,0,0,0, 1,0,0);
    add(0,0,0,0,0,0,0,1,7,0, 0,0,0);
    add(0,0,0,0,0,0,0,1,7,0, 0,0,0);
    add(0,0,0,0,0,0,0,1,7,0, 0,0,0);
    add(1,0,0,1,7,0,0,0,0,0, 0,1,0);
    // same-register issue and write-back, count 1 then count 0
    add(1,0,0,0,0,1,9,0,0,0, 0,1,0);
    add(1,0,0,0,0,1,9,1,9,0, 0,1,0);
    add(1,1,9,0,0,0,0,0,0,0, 1,0,0);
    add(0,0,0,0,0,0,0,1,9,0, 0,0,0);
    add(1,0,0,0,0,1,9,1,9,0, 0,1,0);
    add(1,1,9,0,0,0,0,0,0,0, 0,1,0);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0);
    // different registers incremented and decremented together
    add(1,0,0,0,0,1,10,0,0,0, 0,1,0);
    add(1,0,0,0,0,1,11,1,10,0, 0,1,0);
    add(1,1,10,1,11,0,0,0,0,0, 1,0,0);
    add(1,1,10,0,0,0,0,0,0,0, 0,1,0);
    add(0,0,0,0,0,0,0,1,11,0, 0,0,0);
    // flush, then write-back to an empty register sets the sticky error
    add(1,0,0,0,0,1,2,0,0,0, 0,1,0);
    add(1,0,0,0,0,1,4,0,0,0, 0,1,0);
    add(1,1,2,0,0,1,5,1,9,1, 0,0,0);
    add(1,1,2,1,4,0,0,0,0,0, 0,1,0);
    add(0,0,0,0,0,0,0,1,2,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,1);
    add(1,1,5,0,0,0,0,0,0,0, 0,1,1);
    add(1,0,0,0,0,1,2,0,0,0, 0,1,1);

    // Reset held with random inputs: pend reads as zero, so no stall is possible
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      t.v = 1'($urandom); t.r1 = 1'($urandom); t.a1 = 5'($urandom);
      t.r2 = 1'($urandom); t.a2 = 5'($urandom); t.w = 1'($urandom);
      t.wa = 5'($urandom); t.wb = 1'($urandom); t.wba = 5'($urandom);
      t.fl = 1'($urandom);
      drive(t);
      #1;
      chk($sformatf("rst%0d stall", i), 32'(stall_o), 32'd0);
      chk($sformatf("rst%0d issue", i), 32'(issue_o), 32'(t.v & ~t.fl));
      chk($sformatf("rst%0d err", i), 32'(err_o), 32'd0);
      chk($sformatf("rst%0d cnt", i), 32'(stall_cnt_o), 32'd0);
    end
    @(negedge clk);
    idle();
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      $display("vec %0d: stall=%0b issue=%0b err=%0b cnt=%0d", i, stall_o, issue_o, err_o, stall_cnt_o);
      chk($sformatf("vec%0d stall", i), 32'(stall_o), 32'(tbl[i].es));
      chk($sformatf("vec%0d issue", i), 32'(issue_o), 32'(tbl[i].ei));
      chk($sformatf("vec%0d err", i), 32'(err_o), 32'(tbl[i].ee));
      chk($sformatf("vec%0d cnt", i), 32'(stall_cnt_o), 32'(exp_cnt));
      if (tbl[i].es) exp_cnt++;
    end

    // r2 is pending from the last vector: hold a dependent read until the counter saturates
    t = '{default: '0};
    t.v = 1'b1; t.r1 = 1'b1; t.a1 = 5'd2;
    n_sat = 65535 - exp_cnt + 3;
    for (int i = 0; i < n_sat; i++) begin
      @(negedge clk);
      drive(t);
    end
    @(negedge clk);
    #1;
    $display("saturate: stall=%0b cnt=%0h err=%0b", stall_o, stall_cnt_o, err_o);
    chk("sat stall", 32'(stall_o), 32'd1);
    chk("sat cnt", 32'(stall_cnt_o), 32'hFFFF);
    chk("sat err", 32'(err_o), 32'd1);

    // Asynchronous reset between clock edges clears everything at once
    #2;
    rst = 1'b0;
    #1;
    $display("async rst: stall=%0b issue=%0b cnt=%0h err=%0b", stall_o, issue_o, stall_cnt_o, err_o);
    chk("arst cnt", 32'(stall_cnt_o), 32'd0);
    chk("arst err", 32'(err_o), 32'd0);
    chk("arst stall", 32'(stall_o), 32'd0);
    chk("arst issue", 32'(issue_o), 32'd1);
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    drive(t);
    #1;
    $display("post rst: stall=%0b issue=%0b cnt=%0h err=%0b", stall_o, issue_o, stall_cnt_o, err_o);
    chk("post stall", 32'(stall_o), 32'd0);
    chk("post issue", 32'(issue_o), 32'd1);
    chk("post cnt", 32'(stall_cnt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register-hazard scoreboard for the decode stage. It tracks, per architectural register, how many issued instructions still have an outstanding write-back. It compares decode's regfile read requests against that state and raises a stall while a read-after-write hazard or a counter overflow exists. It sits beside the decode stage, takes its read-enable/address and write-target signals, and takes completion events from the write-back stage.

## Interface
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero and never tracked
- ADDR_W, 5, register address width
- CNT_W, 2, width of each per-register pending counter (max 3 in flight per register)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode holds a valid instruction this cycle
- reg1_read_i  in  1  read port 1 used by the instruction
- reg1_addr_i  in  ADDR_W  read port 1 address
- reg2_read_i  in  1  read port 2 used
- reg2_addr_i  in  ADDR_W  read port 2 address
- reg_write_i  in  1  instruction writes a register
- waddr_i  in  ADDR_W  destination register
- wb_valid_i  in  1  a write-back completes this cycle
- wb_addr_i  in  ADDR_W  register being written back
- flush_i  in  1  pipeline flush; discard all pending state
- stall_o  out  1  decode must hold (combinational)
- issue_o  out  1  instruction leaves decode this cycle (combinational)
- err_o  out  1  sticky: write-back to a register with zero pending count
- stall_cnt_o  out  16  saturating count of stalled valid cycles

## Operation
- State: pend[r], CNT_W bits each, for r = 1..REG_NUM-1. pend[0] reads as 0 always.
- Hazard terms (all from registered pend only):
  - raw1 = reg1_read_i & reg1_addr_i≠0 & pend[reg1_addr_i]≠0
  - raw2 is the same expression using port 2.
  - waw_full = reg_write_i & waddr_i≠0 & pend[waddr_i]==max(CNT_W)
- stall_o = id_valid_i & ~flush_i & (raw1 | raw2 | waw_full).
- issue_o = id_valid_i & ~flush_i & ~stall_o.
- Increment: on issue_o & reg_write_i & waddr_i≠0, pend[waddr_i] += 1.
- Decrement: on wb_valid_i & wb_addr_i≠0, pend[wb_addr_i] -= 1 when non-zero. If it is already zero, pend is unchanged and err_o sets.
- Same register incremented and decremented in one cycle: net unchanged, no error, including when the count is 0.
- Different registers incremented and decremented in one cycle: both updates apply.
- wb_addr_i = 0 and waddr_i = 0 are ignored.
- flush_i: all pend cleared at the next edge. Write-back and issue in that cycle are discarded. err_o is not affected.
- stall_cnt_o increments on every cycle with stall_o = 1 and saturates at 16'hFFFF.
- err_o is cleared only by reset.

## Timing
- Reset (rst low, asynchronous): all pend = 0, err_o = 0, stall_cnt_o = 0.
- Outputs during reset: stall_o and issue_o follow their combinational equations with pend = 0.
- stall_o and issue_o are purely combinational, with zero-cycle latency from the inputs.
- A write-back in cycle N clears the hazard it resolves in cycle N+1. There is no same-cycle bypass.
- An issue in cycle N makes its destination hazardous to readers from cycle N+1.
- A dependent instruction therefore stalls at least from N+1 until one cycle after the matching write-back.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- Deasserting reset takes effect at the next rising edge.

## Test plan
- Reset: hold rst=0 with random inputs, then release → err_o=0, stall_cnt_o=0. Then id_valid_i=1 with reg1_read_i=1, reg1_addr_i=5 → stall_o=0, issue_o=1.
- RAW stall and release: issue a write to r3 at cycle 0, then present a read of r3 from cycle 1 → stall_o=1 for cycles 1–4. Write-back of r3 at cycle 4 → stall_o=0 and issue_o=1 at cycle 5; stall_cnt_o=4.
- r0 exemption: write r0, then read r0 on both ports → never stalls; pend unchanged; a write-back to r0 sets no error.
- Saturation: issue 3 writes to r7 with no write-back → the 4th write to r7 has stall_o=1. One write-back of r7 → the 4th write issues on the next cycle.
- Simultaneous events: pend[9]=1, then issue a write to r9 and write back r9 in the same cycle → pend[9] stays 1 and the next read of r9 still stalls.
  - Zero-count variant: pend[9]=0 with the same-cycle issue and write-back → pend[9] stays 0 and err_o stays 0.
- Flush and error: issue writes to r2 and r4, then assert flush_i for one cycle → stall_o=0 and issue_o=0 that cycle, and reads of r2/r4 issue next cycle. A later write-back to r2 sets err_o=1, which stays 1 until reset.
